relu_maxpool: RTL
=================

Name: relu_maxpool

Overview:
- Downstream consumer of the convolution layer output: 32 channels × 12 positions (3 rows × 4 cols per channel).
- Applies ReLU, then 2×2 stride-2 max pooling in ceil mode, giving a 2×2 map per channel.
- Processes one channel per cycle under a small FSM and raises a one-cycle valid when the pooled tensor is complete.
- Intended to feed the next layer's zero-padding stage.

Parameters:
- DATA_LEN, 16: element width; signed two's complement.
- CH, 32: channel count.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  reset; asynchronous, active-high.
- load  input  1  start request; a rising edge is detected internally; level-held input is tolerated.
- d  input  CH*12*DATA_LEN  conv output; element c*12+r*4+k occupies bits [(idx+1)*DATA_LEN-1 : idx*DATA_LEN].
- busy  output  1  high in LOAD_CAP, CALC and DONE.
- valid  output  1  one-cycle pulse; q is complete in this cycle.
- q  output  CH*4*DATA_LEN  pooled result; element c*4+pr*2+pc, same bit packing as d.

Behaviour:
- Reset (async, active-high): state=IDLE, ch=0, load_d=0, valid=0, busy=0, captured buffer=0, q=0. Applies immediately, including mid-CALC; a partial result is discarded.
- Start detection: start = load & ~load_d. load_d is registered every cycle.
- start is honoured only in IDLE. In all other states it is ignored, and no edge is remembered.
- FSM states IDLE, LOAD_CAP, CALC, DONE:
  - IDLE: on start -> LOAD_CAP.
  - LOAD_CAP: on the clock edge, d is copied into an internal buffer; ch=0; -> CALC. d may change freely after this edge.
  - CALC: each edge writes the 4 pooled values of channel ch into q and increments ch. After the edge with ch=CH-1 -> DONE; ch wraps to 0.
  - DONE: valid=1 for exactly this cycle, then -> IDLE.
- Latency: start seen at edge E0. Capture at E1, channels at E2..E(CH+1), valid high during the cycle after E(CH+1). That is CH+2 edges after the start edge; 34 for CH=32.
- q during CALC is partially updated and undefined for the consumer. q holds its value from DONE until the next LOAD_CAP completes its first CALC write.
- Pool windows per channel, for input rows r 0..2 and cols k 0..3:
  - (pr=0,pc) covers rows 0-1, cols 2pc..2pc+1: 4 elements.
  - (pr=1,pc) covers row 2 only, cols 2pc..2pc+1: 2 elements. Ceil mode; rows beyond 2 do not exist and contribute nothing.
- Output = max(0, max(window)), using signed comparison. Equivalent to ReLU before max.
- Results are never negative. The most negative value (-2^(DATA_LEN-1)) maps to 0. No saturation is needed; width is unchanged.
- Ties output the common value.
- If load stays high from the previous DONE, no restart occurs until load falls and rises again.

Test Plan:
- Reset, then all d elements = +1..+12 ramp per channel (value = r*4+k+1) -> after 34 edges valid pulses once; each channel q = {6,8,10,12} for (0,0),(0,1),(1,0),(1,1).
- All d elements = -5 -> valid after 34 edges; q all zero. Repeat with 0x8000 in every element -> q all zero.
- Channel c gets value c-16 in all 12 positions -> q channel c = max(0,c-16) in all 4 outputs; channel 31 = 15, channels 0..16 = 0.
- Second rising edge of load 5 cycles after start -> ignored; exactly one valid at edge 34; q matches the first capture. d changed after capture -> no effect on q.
- Assert rst at cycle 10 of CALC -> busy, valid and q go to 0 immediately. Release, then give a fresh start -> correct full result 34 edges later.
- load held high for 100 cycles -> exactly one valid. Drop load for 1 cycle and raise it again -> a second valid 34 edges after the new edge.

Source files
------------

// File: rtl/relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool
// Purpose  : ReLU + 2x2/stride-2 ceil-mode max pooling of a CH x (3x4) conv
//            output. Captures the input on a load rising edge, produces one
//            channel per cycle, and pulses valid when all channels are done.
// Revision : 1.0 - initial release
// ============================================================================
module relu_maxpool #(
  parameter int DATA_LEN = 16,
  parameter int CH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [CH*12*DATA_LEN-1:0]  d,
  output logic                       busy,
  output logic                       valid,
  output logic [CH*4*DATA_LEN-1:0]   q
);

  localparam int C_CH_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int C_IN_W  = 12 * DATA_LEN;  // one channel of input: 3 rows x 4 cols
  localparam int C_OUT_W = 4 * DATA_LEN;   // one channel of output: 2 x 2

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LOAD_CAP = 2'd1,
    S_CALC     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [C_CH_W-1:0]          ch_q, ch_d;
  logic                       load_prev_q;
  logic [CH*C_IN_W-1:0]       buf_q;
  logic [CH*C_OUT_W-1:0]      q_q;

  logic                       w_start;
  logic                       w_cap_en;
  logic                       w_wr_en;
  logic [C_IN_W-1:0]          w_chan;
  logic [C_OUT_W-1:0]         w_pool;
  logic signed [DATA_LEN-1:0] w_elem [12];

  // Signed maximum of two elements.
  function automatic logic signed [DATA_LEN-1:0] smax(
    input logic signed [DATA_LEN-1:0] a,
    input logic signed [DATA_LEN-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Clamp negatives to zero; the most negative code also maps to zero.
  function automatic logic [DATA_LEN-1:0] relu(input logic signed [DATA_LEN-1:0] x);
    return x[DATA_LEN-1] ? '0 : x;
  endfunction

  // Only a fresh rising edge of load counts; a held level never restarts.
  assign w_start = load & ~load_prev_q;

  // Channel currently being pooled, taken from the captured copy of d.
  assign w_chan = buf_q[ch_q*C_IN_W +: C_IN_W];

  generate
    for (genvar i = 0; i < 12; i++) begin : g_elem
      assign w_elem[i] = w_chan[i*DATA_LEN +: DATA_LEN];
    end

    // Top row of the pooled map sees input rows 0-1; the bottom row only has
    // input row 2 available (ceil mode), so its window is two elements wide.
    for (genvar pc = 0; pc < 2; pc++) begin : g_pc
      logic signed [DATA_LEN-1:0] w_top;
      logic signed [DATA_LEN-1:0] w_bot;

      assign w_top = smax(smax(w_elem[2*pc],     w_elem[2*pc+1]),
                          smax(w_elem[4+2*pc],   w_elem[5+2*pc]));
      assign w_bot = smax(w_elem[8+2*pc], w_elem[9+2*pc]);

      assign w_pool[pc*DATA_LEN     +: DATA_LEN] = relu(w_top);
      assign w_pool[(2+pc)*DATA_LEN +: DATA_LEN] = relu(w_bot);
    end
  endgenerate

  // Next-state and control decode for the capture / per-channel sequencer.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    w_cap_en = 1'b0;
    w_wr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_start) begin
          state_d = S_LOAD_CAP;
        end
      end
      S_LOAD_CAP: begin
        w_cap_en = 1'b1;
        ch_d     = '0;
        state_d  = S_CALC;
      end
      S_CALC: begin
        w_wr_en = 1'b1;
        if (ch_q == C_CH_W'(CH - 1)) begin
          ch_d    = '0;
          state_d = S_DONE;
        end else begin
          ch_d = ch_q + C_CH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state, channel counter and load edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      load_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      load_prev_q <= load;
    end
  end

  // Snapshot of d so the producer may change it right after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
    end else if (w_cap_en) begin
      buf_q <= d;
    end
  end

  // Pooled result, written one channel per CALC cycle and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (w_wr_en) begin
      q_q[ch_q*C_OUT_W +: C_OUT_W] <= w_pool;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign valid = (state_q == S_DONE);
  assign q     = q_q;

endmodule
`default_nettype wire
